// File: rtl/l_class_oc_heard_arbiter_pkg.sv
// rtl/l_class_oc_heard_arbiter_pkg.sv - shared sizes and call record for the heard arbiter
package l_class_oc_heard_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int DEPTH = 2;
    localparam int W     = 32;

    localparam int SRC_W = $clog2(NREQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0] meth;
        logic [W-1:0] v;
    } heard_call_t;

endpackage

// File: rtl/l_class_oc_heard_arbiter_fifo.sv
// rtl/l_class_oc_heard_arbiter_fifo.sv - DEPTH-entry heard_call_t FIFO with full/empty/count
module l_heard_fifo
    import l_class_oc_heard_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  heard_call_t      wdata,
    output heard_call_t      rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    heard_call_t      mem_q [DEPTH];
    heard_call_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Guards are repeated here so the FIFO stays safe if a caller ignores full/empty.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/l_class_oc_heard_arbiter.sv
// rtl/l_class_oc_heard_arbiter.sv - round-robin merge of NREQ heard callers onto one registered output
module l_class_oc_heard_arbiter
    import l_class_oc_heard_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NREQ-1:0]   req_heard_ena,
    input  logic [NREQ*W-1:0] req_heard_meth,
    input  logic [NREQ*W-1:0] req_heard_v,
    output logic [NREQ-1:0]   req_heard_rdy,
    output logic              indication_heard_ena,
    output logic [W-1:0]      indication_heard_meth,
    output logic [W-1:0]      indication_heard_v,
    input  logic              indication_heard_rdy,
    output logic [SRC_W-1:0]  grant_src,
    output logic              busy
);

    logic [NREQ-1:0]  q_full, q_empty, q_push, q_pop;
    logic [CNT_W-1:0] q_count [NREQ];
    heard_call_t      q_rdata [NREQ];

    heard_call_t      out_call_q, out_call_d;
    logic             out_valid_q, out_valid_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             xfer, can_load, grant_hit, grant;
    logic [SRC_W-1:0] winner, idx;
    logic             any_queued;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_q
        assign q_push[gi] = req_heard_ena[gi] & ~q_full[gi];

        l_heard_fifo u_fifo (
            .clk   (CLK),
            .rst_n (nRST),
            .push  (q_push[gi]),
            .pop   (q_pop[gi]),
            .wdata ({req_heard_meth[gi*W +: W], req_heard_v[gi*W +: W]}),
            .rdata (q_rdata[gi]),
            .full  (q_full[gi]),
            .empty (q_empty[gi]),
            .count (q_count[gi])
        );
    end

    // Ready comes straight from registered fullness; a pop in the same cycle does not free a slot early.
    assign req_heard_rdy = ~q_full;

    // Round-robin search from rr_ptr; NREQ is a power of two so the index wraps for free.
    always_comb begin
        xfer      = out_valid_q & indication_heard_rdy;
        can_load  = ~out_valid_q | xfer;
        grant_hit = 1'b0;
        winner    = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr_q + SRC_W'(k);
            if (!grant_hit && !q_empty[idx]) begin
                grant_hit = 1'b1;
                winner    = idx;
            end
        end
        grant = can_load & grant_hit;
        q_pop = '0;
        if (grant) begin
            q_pop[winner] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_call_d  = out_call_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant) begin
            out_valid_d = 1'b1;
            out_call_d  = q_rdata[winner];
            out_src_d   = winner;
            rr_ptr_d    = winner + SRC_W'(1);
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        any_queued = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            any_queued = any_queued | (q_count[i] != '0);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q <= 1'b0;
            out_call_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_call_q  <= out_call_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign indication_heard_ena  = out_valid_q;
    assign indication_heard_meth = out_call_q.meth;
    assign indication_heard_v    = out_call_q.v;
    assign grant_src             = out_src_q;
    assign busy                  = out_valid_q | any_queued;

endmodule

// File: tb/tb_l_class_oc_heard_arbiter.sv
// tb/tb_l_class_oc_heard_arbiter.sv - scoreboard bench for the heard arbiter
module tb_l_class_oc_heard_arbiter;
    import l_class_oc_heard_arbiter_pkg::*;

    logic              CLK;
    logic              nRST;
    logic [NREQ-1:0]   req_ena;
    logic [NREQ*W-1:0] req_meth;
    logic [NREQ*W-1:0] req_v;
    logic [NREQ-1:0]   req_rdy;
    logic              ind_ena;
    logic [W-1:0]      ind_meth;
    logic [W-1:0]      ind_v;
    logic              ind_rdy;
    logic [SRC_W-1:0]  grant_src;
    logic              busy;

    l_class_oc_heard_arbiter dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .req_heard_ena         (req_ena),
        .req_heard_meth        (req_meth),
        .req_heard_v           (req_v),
        .req_heard_rdy         (req_rdy),
        .indication_heard_ena  (ind_ena),
        .indication_heard_meth (ind_meth),
        .indication_heard_v    (ind_v),
        .indication_heard_rdy  (ind_rdy),
        .grant_src             (grant_src),
        .busy                  (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: per-requester queues, one held call, a rotating priority start, and the
    // list of calls expected downstream in order (pushed when a call is taken into the output).
    heard_call_t   mq [NREQ][$];
    bit            m_valid;
    int            m_rr;
    logic [65:0]   sb [$];

    task automatic model_clear();
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        m_valid = 0;
        m_rr    = 0;
        sb.delete();
    endtask

    task automatic model_step();
        bit             xfer;
        int             win;
        int             j;
        bit [NREQ-1:0]  acc;
        heard_call_t    c;
        xfer = m_valid && ind_rdy;
        for (int i = 0; i < NREQ; i++) acc[i] = req_ena[i] && (mq[i].size() < DEPTH);
        win = -1;
        if (!m_valid || xfer) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_rr + k) % NREQ;
                if (win < 0 && mq[j].size() > 0) win = j;
            end
        end
        if (win >= 0) begin
            c = mq[win].pop_front();
            sb.push_back({2'(win), c.meth, c.v});
            m_valid = 1;
            m_rr    = (win + 1) % NREQ;
        end else if (xfer) begin
            m_valid = 0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                c.meth = req_meth[i*W +: W];
                c.v    = req_v[i*W +: W];
                mq[i].push_back(c);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            if (!nRST) model_clear();
            else model_step();
        end
    end

    initial begin
        logic [NREQ-1:0] exp_rdy;
        bit              exp_busy;
        logic [65:0]     e;
        forever begin
            @(negedge CLK);
            if (nRST) begin
                exp_busy = m_valid;
                for (int i = 0; i < NREQ; i++) begin
                    exp_rdy[i] = (mq[i].size() < DEPTH);
                    if (mq[i].size() > 0) exp_busy = 1;
                end
                chk("mon_rdy", 66'(req_rdy), 66'(exp_rdy));
                chk("mon_ena", 66'(ind_ena), 66'(m_valid));
                chk("mon_busy", 66'(busy), 66'(exp_busy));
                if (ind_ena && ind_rdy) begin
                    chk("sb_has_entry", 66'(sb.size() != 0), 66'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("xfer_src_meth_v", {grant_src, ind_meth, ind_v}, e);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] m, input logic [W-1:0] v);
        req_meth[i*W +: W] = m;
        req_v[i*W +: W]    = v;
    endtask

    task automatic mid_reset();
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        model_clear();
        #1;
        chk("rst_async_ena", 66'(ind_ena), 66'd0);
        chk("rst_async_busy", 66'(busy), 66'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        chk("rst_rel_rdy", 66'(req_rdy), 66'hf);
        chk("rst_rel_ena", 66'(ind_ena), 66'd0);
    endtask

    initial begin
        nRST     = 1'b0;
        req_ena  = '0;
        req_meth = '0;
        req_v    = '0;
        ind_rdy  = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_ena", 66'(ind_ena), 66'd0);
        chk("reset_busy", 66'(busy), 66'd0);
        chk("reset_rdy", 66'(req_rdy), 66'hf);
        chk("reset_src", 66'(grant_src), 66'd0);
        chk("reset_meth_v", {ind_meth, ind_v}, 66'd0);
        nRST = 1'b1;
        cyc();

        // single call from requester 1, then rotation from rr_ptr=2
        ind_rdy = 1'b1;
        set_req(1, 32'd5, 32'h1234);
        req_ena = 4'b0010;
        cyc();
        req_ena = '0;
        cyc();
        chk("single_ena", 66'(ind_ena), 66'd1);
        chk("single_meth", 66'(ind_meth), 66'd5);
        chk("single_v", 66'(ind_v), 66'h1234);
        chk("single_src", 66'(grant_src), 66'd1);
        cyc();
        chk("single_idle_ena", 66'(ind_ena), 66'd0);
        chk("single_idle_busy", 66'(busy), 66'd0);

        set_req(0, 32'ha0, 32'hb0);
        set_req(3, 32'ha3, 32'hb3);
        req_ena = 4'b1001;
        cyc();
        req_ena = '0;
        cyc();
        chk("rot_first_src", 66'(grant_src), 66'd3);
        cyc();
        chk("rot_second_src", 66'(grant_src), 66'd0);
        cyc();
        chk("rot_done_ena", 66'(ind_ena), 66'd0);

        // fairness from a fresh pointer
        mid_reset();
        ind_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(16 + i), 32'(32 + i));
        req_ena = 4'b1111;
        cyc();
        req_ena = '0;
        for (int k = 0; k < NREQ; k++) begin
            cyc();
            chk("fair_order_src", 66'(grant_src), 66'(k));
            chk("fair_order_meth", 66'(ind_meth), 66'(16 + k));
        end
        cyc();
        chk("fair_done_ena", 66'(ind_ena), 66'd0);
        req_ena = 4'b1001;
        cyc();
        req_ena = '0;
        cyc();
        chk("fair_ptr_wrapped_src", 66'(grant_src), 66'd0);
        repeat (2) cyc();

        // backpressure on requester 2
        mid_reset();
        ind_rdy = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (n == 3) chk("bp_rdy2_full", 66'(req_rdy[2]), 66'd0);
            set_req(2, 32'(100 + n), 32'(200 + n));
            req_ena = 4'b0100;
            cyc();
        end
        req_ena = '0;
        for (int n = 0; n < 3; n++) begin
            chk("bp_hold_ena", 66'(ind_ena), 66'd1);
            chk("bp_hold_meth_v", {ind_meth, ind_v}, {34'd100, 32'd200});
            cyc();
        end
        ind_rdy = 1'b1;
        cyc();
        chk("bp_second_meth", 66'(ind_meth), 66'd101);
        cyc();
        chk("bp_third_meth", 66'(ind_meth), 66'd102);
        cyc();
        chk("bp_refused_absent", 66'(ind_ena), 66'd0);

        // full queue 0 while the output drains
        mid_reset();
        ind_rdy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_req(0, 32'(8'h10 + n), 32'(8'h20 + n));
            req_ena = 4'b0001;
            cyc();
        end
        chk("full0_rdy_low", 66'(req_rdy[0]), 66'd0);
        ind_rdy = 1'b1;
        set_req(0, 32'h13, 32'h23);
        cyc();
        req_ena = '0;
        chk("full0_rdy_back", 66'(req_rdy[0]), 66'd1);
        chk("full0_next_meth", 66'(ind_meth), 66'h11);
        cyc();
        chk("full0_last_meth", 66'(ind_meth), 66'h12);
        cyc();
        chk("full0_refused_absent", 66'(ind_ena), 66'd0);

        // reset with five calls outstanding
        ind_rdy = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(64 + i), 32'(80 + i));
        req_ena = 4'b1111;
        cyc();
        req_ena = 4'b0001;
        cyc();
        req_ena = '0;
        chk("pre_rst_busy", 66'(busy), 66'd1);
        mid_reset();
        ind_rdy = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk("post_rst_quiet", 66'(ind_ena), 66'd0);
        end

        // random traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, $urandom(), $urandom());
            req_ena = 4'($urandom_range(0, 15));
            ind_rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        req_ena = '0;
        ind_rdy = 1'b1;
        repeat (12) cyc();
        chk("drain_sb_empty", 66'(sb.size()), 66'd0);
        chk("drain_ena", 66'(ind_ena), 66'd0);
        chk("drain_busy", 66'(busy), 66'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
